// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: default register-file geometry, the x0
// index and the LUI opcode used by decode to force the rs1 operand to zero.
package rv_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned REG_ZERO  = 0;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;

  // Decode helper: LUI takes no rs1 operand, so its rs1 read is forced to 0.
  function automatic logic is_lui(input logic [6:0] opcode);
    return opcode == OP_LUI;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for the integer register file.
// Tracks which architectural registers have an in-flight producer, keeps a
// running count of busy registers and raises a sticky protocol error on a
// rejected (WAW) issue or on a writeback to a register with no producer.
// Ports:
//   clk, rst                 clock, async active-high reset
//   rs1_addr/rs2_addr        read-port addresses; rs1_zero masks port 1
//   rs1_busy/rs2_busy        read operand still has a pending producer
//   issue_valid/issue_rd     issuing instruction and its destination
//   issue_ready              destination free, issue accepted
//   wb_valid/wb_addr         writeback strobe and destination
//   busy_count               number of busy registers
//   err                      sticky protocol error
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter bit          BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          rs1_zero,
  output logic          rs1_busy,
  output logic          rs2_busy,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  output logic [AW:0]   busy_count,
  output logic          err
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);
  localparam logic [AW:0]   One  = (AW+1)'(1);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;
  logic             err_q, err_d;

  logic set_en, clr_busy, orphan, reject, wb_hit;

  always_comb begin
    issue_ready = (issue_rd == Zero) || !busy_q[issue_rd];
    set_en      = issue_valid && issue_ready && (issue_rd != Zero);
    reject      = issue_valid && !issue_ready;
    wb_hit      = wb_valid && (wb_addr != Zero);
    clr_busy    = wb_hit && busy_q[wb_addr];
    // A writeback racing the issue of the same register is not an orphan.
    orphan      = wb_hit && !busy_q[wb_addr] && !(set_en && (issue_rd == wb_addr));

    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    // Set after clear so a new producer wins over the retiring one.
    if (set_en)   busy_d[issue_rd] = 1'b1;

    // set_en needs a free register, so set and clear never hit the same bit.
    count_d = count_q;
    case ({set_en, clr_busy})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase

    err_d = err_q | reject | orphan;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // A same-cycle writeback retires the producer, so the operand is usable now.
  always_comb begin
    rs1_busy = busy_q[rs1_addr] && !(BYPASS && wb_valid && (wb_addr == rs1_addr));
    if (rs1_zero || (rs1_addr == Zero)) rs1_busy = 1'b0;
    rs2_busy = busy_q[rs2_addr] && !(BYPASS && wb_valid && (wb_addr == rs2_addr));
    if (rs2_addr == Zero) rs2_busy = 1'b0;
  end

  assign busy_count = count_q;
  assign err        = err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with busy scoreboard for the pipelined RV32I core.
// Two combinational read ports, one write port, optional same-cycle
// writeback forwarding, x0 hard-wired to zero.
// Ports:
//   clk, rst                 clock, async active-high reset
//   rs1_addr/rs2_addr        read addresses; rs1_zero forces rs1_data to 0
//   rs1_data/rs2_data        read data (combinational)
//   rs1_busy/rs2_busy        operand has a pending producer
//   issue_valid/issue_rd     issuing instruction writes issue_rd
//   issue_ready              issue_rd is free
//   wb_valid/wb_addr/wb_data writeback port
//   busy_count               number of busy registers
//   err                      sticky protocol error
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = $clog2(NREGS),  // derived, leave at default
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_zero,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     busy_count,
  output logic            err
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  // Entry 0 is never written; it only holds its reset value.
  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wb_valid && (wb_addr != Zero)) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  // Overrides applied lowest priority first.
  always_comb begin
    rs1_data = mem_q[rs1_addr];
    if (BYPASS && wb_valid && (wb_addr == rs1_addr)) rs1_data = wb_data;
    if (rs1_zero || (rs1_addr == Zero)) rs1_data = '0;

    rs2_data = mem_q[rs2_addr];
    if (BYPASS && wb_valid && (wb_addr == rs2_addr)) rs2_data = wb_data;
    if (rs2_addr == Zero) rs2_data = '0;
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_zero    (rs1_zero),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .busy_count  (busy_count),
    .err         (err)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one instance with forwarding, one without,
// both driven by the same stimulus.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
  logic        rs1_zero, issue_valid, wb_valid;
  logic [31:0] wb_data;

  logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic        rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
  logic        issue_ready, nb_issue_ready, err, nb_err;
  logic [5:0]  busy_count, nb_busy_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_zero(rs1_zero),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_count(busy_count), .err(err)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_zero(rs1_zero),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .rs1_busy(nb_rs1_busy),
    .rs2_busy(nb_rs2_busy), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(nb_issue_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_count(nb_busy_count), .err(nb_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_err;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a, input logic z, input bit byp);
    if (z || a == 0) return 32'h0;
    if (byp && wb_valid && wb_addr == a) return wb_data;
    return m_mem[a];
  endfunction

  function automatic logic m_bsy(input logic [4:0] a, input logic z, input bit byp);
    if (z || a == 0) return 1'b0;
    if (byp && wb_valid && wb_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic m_ready();
    return issue_rd == 0 || !m_busy[issue_rd];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic m_step();
    bit acc;
    acc = issue_valid && m_ready() && issue_rd != 0;
    if (issue_valid && !m_ready()) m_err = 1'b1;
    if (wb_valid && wb_addr != 0 && !m_busy[wb_addr] && !(acc && issue_rd == wb_addr))
      m_err = 1'b1;
    if (wb_valid && wb_addr != 0) m_mem[wb_addr] = wb_data;
    if (wb_valid) m_busy[wb_addr] = 1'b0;
    if (acc) m_busy[issue_rd] = 1'b1;
  endtask

  task automatic check_model();
    chk("rnd rs1_data", rs1_data, m_rd(rs1_addr, rs1_zero, 1'b1));
    chk("rnd rs2_data", rs2_data, m_rd(rs2_addr, 1'b0, 1'b1));
    chk("rnd rs1_busy", rs1_busy, m_bsy(rs1_addr, rs1_zero, 1'b1));
    chk("rnd rs2_busy", rs2_busy, m_bsy(rs2_addr, 1'b0, 1'b1));
    chk("rnd issue_ready", issue_ready, m_ready());
    chk("rnd busy_count", busy_count, m_count());
    chk("rnd err", err, m_err);
    chk("rnd nb rs1_data", nb_rs1_data, m_rd(rs1_addr, rs1_zero, 1'b0));
    chk("rnd nb rs2_data", nb_rs2_data, m_rd(rs2_addr, 1'b0, 1'b0));
    chk("rnd nb rs1_busy", nb_rs1_busy, m_bsy(rs1_addr, rs1_zero, 1'b0));
    chk("rnd nb rs2_busy", nb_rs2_busy, m_bsy(rs2_addr, 1'b0, 1'b0));
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
    rs1_addr = 0; rs2_addr = 0; rs1_zero = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_clear();
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic wv,
                       input logic [4:0] wa, input logic [31:0] wd);
    issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_addr = wa; wb_data = wd;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic iv; logic [4:0] ird; logic wv; logic [4:0] wa; logic [31:0] wd;
    logic [4:0] r1; logic [4:0] r2; logic z;
    logic [31:0] e_r1; logic [31:0] e_r2; logic [31:0] e_r2_nb;
    logic e_b1; logic e_b1_nb; logic e_rdy;
    logic [5:0] e_cnt; logic e_err;  // sampled after the edge
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 5, 0, 0, 0,           5, 0, 0, 0, 0, 0,                0, 0, 1, 1, 0};
    tbl[1]  = '{0, 0, 1, 5, 32'hDEADBEEF, 5, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 32'h1234,    5, 0, 0, 32'hDEADBEEF, 0, 0,     0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0,           0, 5, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 7, 0, 0, 0,           7, 7, 0, 0, 0, 0,                0, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 1, 7, 32'hA5A5A5A5, 3, 7, 0, 0, 32'hA5A5A5A5, 0,     0, 0, 1, 0, 0};
    tbl[6]  = '{1, 3, 0, 0, 0,           3, 7, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1, 1, 0};
    tbl[7]  = '{0, 3, 0, 0, 0,           3, 0, 0, 0, 0, 0,                1, 1, 0, 1, 0};
    tbl[8]  = '{1, 3, 0, 0, 0,           3, 0, 0, 0, 0, 0,                1, 1, 0, 1, 1};
    tbl[9]  = '{0, 3, 1, 3, 32'h33,      3, 3, 0, 32'h33, 32'h33, 0,      0, 1, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0,           5, 5, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 0, 1};
    tbl[11] = '{1, 4, 1, 4, 32'h44,      4, 4, 0, 32'h44, 32'h44, 0,      0, 0, 1, 1, 1};
    tbl[12] = '{0, 4, 0, 0, 0,           4, 3, 0, 32'h44, 32'h33, 32'h33, 1, 1, 0, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 0,           4, 4, 1, 0, 32'h44, 32'h44,      0, 0, 1, 1, 1};

    // Reset state: every register reads 0 and idle.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      #1;
      chk("reset rs1_data", rs1_data, 0);
      chk("reset rs2_data", rs2_data, 0);
      chk("reset rs1_busy", rs1_busy, 0);
      chk("reset rs2_busy", rs2_busy, 0);
    end
    chk("reset busy_count", busy_count, 0);
    chk("reset err", err, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].ird, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      rs1_addr = tbl[i].r1; rs2_addr = tbl[i].r2; rs1_zero = tbl[i].z;
      #2;
      chk($sformatf("vec%0d rs1_data", i), rs1_data, tbl[i].e_r1);
      chk($sformatf("vec%0d rs2_data", i), rs2_data, tbl[i].e_r2);
      chk($sformatf("vec%0d nb rs2_data", i), nb_rs2_data, tbl[i].e_r2_nb);
      chk($sformatf("vec%0d rs1_busy", i), rs1_busy, tbl[i].e_b1);
      chk($sformatf("vec%0d nb rs1_busy", i), nb_rs1_busy, tbl[i].e_b1_nb);
      chk($sformatf("vec%0d issue_ready", i), issue_ready, tbl[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d busy_count", i), busy_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d err", i), err, tbl[i].e_err);
    end

    // Writeback racing the issue of a free register: set wins, no error.
    do_reset();
    drive(1, 8, 1, 8, 32'h88);
    @(posedge clk); #1;
    idle(); rs1_addr = 8; #1;
    chk("race busy_count", busy_count, 1);
    chk("race rs1_busy", rs1_busy, 1);
    chk("race err", err, 0);
    chk("race rs1_data", rs1_data, 32'h88);

    // Orphan writeback: flagged, but the write still lands.
    drive(0, 0, 1, 6, 32'h66);
    @(posedge clk); #1;
    idle(); rs1_addr = 6; #1;
    chk("orphan err", err, 1);
    chk("orphan rs1_data", rs1_data, 32'h66);
    chk("orphan busy_count", busy_count, 1);

    // Async reset between edges with three busy registers and x9=5.
    do_reset();
    drive(1, 9, 0, 0, 0);        @(posedge clk); #1;
    drive(1, 10, 1, 9, 32'd5);   @(posedge clk); #1;
    drive(1, 11, 0, 0, 0);       @(posedge clk); #1;
    drive(1, 12, 0, 0, 0);       @(posedge clk); #1;
    idle(); rs1_addr = 9; rs2_addr = 10; #1;
    chk("pre-rst busy_count", busy_count, 3);
    chk("pre-rst rs1_data", rs1_data, 5);
    chk("pre-rst rs2_busy", rs2_busy, 1);
    chk("pre-rst err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst busy_count", busy_count, 0);
    chk("async rst rs1_data", rs1_data, 0);
    chk("async rst rs2_busy", rs2_busy, 0);
    #1 rst = 1'b0;
    #1;
    chk("post rst rs1_data", rs1_data, 0);
    chk("post rst err", err, 0);
    m_clear();

    // Randomised traffic against the model.
    @(posedge clk); #1;
    for (int c = 0; c < 800; c++) begin
      int nb;
      logic [4:0] bl [$];
      if ($urandom_range(0, 149) == 0) do_reset();
      bl.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) bl.push_back(5'(r));
      nb = bl.size();
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 11));
      wb_valid    = 1'($urandom_range(0, 1));
      if (nb > 0 && $urandom_range(0, 9) != 0) wb_addr = bl[$urandom_range(0, nb - 1)];
      else wb_addr = 5'($urandom_range(0, 11));
      wb_data  = $urandom;
      rs1_addr = ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom_range(0, 11));
      rs2_addr = ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom_range(0, 31));
      rs1_zero = ($urandom_range(0, 7) == 0);
      #2;
      check_model();
      @(posedge clk);
      m_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
